// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order write-back queue with youngest-match forwarding to ID read ports
module wb_write_queue #(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter bit DROP_R0 = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [ADDR_W-1:0]        in_rd,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic                     rf_ready,
    output logic                     RegWrite,
    output logic [ADDR_W-1:0]        writeReg,
    output logic [DATA_W-1:0]        writeDat,
    input  logic [ADDR_W-1:0]        rs,
    input  logic [ADDR_W-1:0]        rt,
    output logic                     fwd1_hit,
    output logic [DATA_W-1:0]        fwd1_data,
    output logic                     fwd2_hit,
    output logic [DATA_W-1:0]        fwd2_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] rd_q  [DEPTH];
    logic [DATA_W-1:0] dat_q [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [PW-1:0]     head, tail;
    logic              push, pop, store;

    assign full     = count == CW'(DEPTH);
    assign empty    = count == '0;
    assign RegWrite = !empty;
    assign pop      = RegWrite & rf_ready;
    assign in_ready = !full | pop;
    assign push     = in_valid & in_ready;
    assign store    = push & !(DROP_R0 && in_rd == '0);
    assign writeReg = empty ? '0 : rd_q[head];
    assign writeDat = empty ? '0 : dat_q[head];

    // scan oldest to youngest so the entry nearest the tail overrides earlier matches
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
        logic [DATA_W:0] r;
        logic [PW-1:0]   idx;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (vld[idx] && rd_q[idx] == a && !(DROP_R0 && a == '0))
                r = {1'b1, dat_q[idx]};
        end
        return r;
    endfunction

    // forward youngest pending value for each ID read address
    always_comb begin
        {fwd1_hit, fwd1_data} = lookup(rs);
        {fwd2_hit, fwd2_data} = lookup(rt);
    end

    // pointers, valid bits and occupancy; a store into the slot being freed keeps it valid
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            if (pop) begin
                head      <= head + 1'b1;
                vld[head] <= 1'b0;
            end
            if (store) begin
                tail      <= tail + 1'b1;
                vld[tail] <= 1'b1;
            end
            count <= count + CW'(store) - CW'(pop);
        end
    end

    // entry payload storage; contents are qualified by vld so no reset is needed
    always_ff @(posedge clock) begin
        if (store) begin
            rd_q[tail]  <= in_rd;
            dat_q[tail] <= in_data;
        end
    end
endmodule
